// File: rtl/cpt_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpt_arbiter_if
// Description : Request/grant and counter-control bundle between the
//               requesters, the shared counter and cpt_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpt_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [WIDTH-1:0]      cpt;
  logic                  cpt_activate;
  logic                  cpt_clear;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;

  // Requester / counter side
  modport master (
    output req, len, cpt,
    input  cpt_activate, cpt_clear, grant, done, busy
  );

  // Arbiter side
  modport slave (
    input  req, len, cpt,
    output cpt_activate, cpt_clear, grant, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/cpt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpt_arbiter
// Description : Round-robin arbiter sharing one external up-counter between
//               NREQ requesters. The winner's length is latched, the counter
//               is cleared, enabled until it reaches that length, then a
//               one-cycle done pulse is returned to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module cpt_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  wire            clk,
  input  wire            reset,   // asynchronous, active-low
  cpt_arbiter_if.slave   bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_winner;
  logic [IW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_target;

  logic             w_pick_valid;
  logic [IW-1:0]    w_pick_idx;
  logic [IW:0]      w_j;
  logic [WIDTH-1:0] w_pick_len;
  logic             w_owner_req;
  logic [NREQ-1:0]  w_onehot;

  assign w_owner_req = bus.req[r_winner];
  assign w_onehot    = {{(NREQ-1){1'b0}}, 1'b1} << r_winner;

  // Round-robin search: first set request at or after the pointer, wrapping.
  // Scanning from the far end lets the nearest hit overwrite the others.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    w_j          = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_j = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_j >= (IW+1)'(NREQ)) begin
        w_j = w_j - (IW+1)'(NREQ);
      end
      if (bus.req[w_j[IW-1:0]]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = w_j[IW-1:0];
      end
    end
  end

  // Select the candidate's length slice with constant indices only.
  always_comb begin
    w_pick_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_idx == IW'(i)) begin
        w_pick_len = bus.len[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; losing the owner's request aborts the run silently.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_next = w_owner_req ? ST_COUNT : ST_IDLE;
      end
      ST_COUNT: begin
        if (!w_owner_req)              w_next = ST_IDLE;
        else if (bus.cpt == r_target)  w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Winner/length capture in IDLE and pointer advance whenever a run ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_winner <= '0;
      r_target <= '0;
      r_ptr    <= '0;
    end else begin
      if (r_state == ST_IDLE && w_pick_valid) begin
        r_winner <= w_pick_idx;
        r_target <= w_pick_len;
      end
      if (r_state != ST_IDLE && w_next == ST_IDLE) begin
        r_ptr <= (r_winner == IW'(NREQ - 1)) ? '0 : r_winner + 1'b1;
      end
    end
  end

  // Output decode; activate also looks at the live counter so it stops
  // exactly on the target without overshooting.
  always_comb begin
    bus.grant        = '0;
    bus.done         = '0;
    bus.cpt_clear    = 1'b0;
    bus.cpt_activate = 1'b0;
    bus.busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_CLEAR: begin
        bus.grant     = w_onehot;
        bus.cpt_clear = 1'b1;
      end
      ST_COUNT: begin
        bus.grant        = w_onehot;
        bus.cpt_activate = (bus.cpt != r_target);
      end
      ST_DONE: begin
        bus.done = w_onehot;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpt_arbiter
// Description : Self-checking bench for cpt_arbiter with a cpt_bin8-style
//               counter model and a done/count scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpt_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  cpt_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  cpt_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Counter model: synchronous clear, +1 per edge while enabled.
  logic [WIDTH-1:0] cpt_q = '0;
  always @(posedge clk) begin
    if (bus.cpt_clear)         cpt_q <= '0;
    else if (bus.cpt_activate) cpt_q <= cpt_q + 1'b1;
  end
  assign bus.cpt = cpt_q;

  typedef struct packed {
    logic [NREQ-1:0]  who;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic set_len(input int i, input logic [WIDTH-1:0] v);
    bus.len[i*WIDTH +: WIDTH] = v;
  endtask

  // Waits (bounded) for a done pulse and reports what was seen.
  task automatic wait_done(input int budget, output logic [NREQ-1:0] d,
                           output logic [WIDTH-1:0] c, output bit to);
    to = 1'b1;
    d  = '0;
    c  = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done !== '0) begin
        d  = bus.done;
        c  = bus.cpt;
        to = 1'b0;
        break;
      end
    end
  endtask

  // Waits (bounded) for a grant; reports whether any done was seen meanwhile.
  task automatic wait_grant(input int budget, output logic [NREQ-1:0] g,
                            output bit saw_done);
    g        = '0;
    saw_done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done !== '0) saw_done = 1'b1;
      if (bus.grant !== '0) begin
        g = bus.grant;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [NREQ-1:0]  d;
    logic [WIDTH-1:0] c;
    bit               to;
    exp_t             e;
    reset   = 1'b0;
    bus.req = 4'b0001;
    bus.len = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if ({bus.grant, bus.done, bus.cpt_clear, bus.cpt_activate, bus.busy} !== '0) begin
        $display("FAIL reset_outputs: got grant=%b done=%b clr=%b act=%b busy=%b expected all 0",
                 bus.grant, bus.done, bus.cpt_clear, bus.cpt_activate, bus.busy);
      end else n_pass++;
    end
    reset = 1'b1;
    exp_q.push_back('{who: 4'b0001, cnt: 8'd0});
    @(negedge clk);
    n_total++;
    if (bus.grant !== 4'b0001 || bus.cpt_clear !== 1'b1) begin
      $display("FAIL reset_first_grant: got grant=%b clr=%b expected grant=0001 clr=1",
               bus.grant, bus.cpt_clear);
    end else n_pass++;
    wait_done(10, d, c, to);
    e = exp_q.pop_front();
    n_total++;
    if (to || d !== e.who || c !== e.cnt) begin
      $display("FAIL reset_done: got done=%b cpt=%0d timeout=%0d expected done=%b cpt=%0d",
               d, c, to, e.who, e.cnt);
    end else n_pass++;
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_run();
    exp_t e;
    set_len(0, 8'd5);
    bus.req = 4'b0001;
    exp_q.push_back('{who: 4'b0001, cnt: 8'd5});
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_total++;
      if (bus.cpt_activate !== ((c >= 2 && c <= 6) ? 1'b1 : 1'b0)) begin
        $display("FAIL single_activate: cycle %0d got %b expected %b",
                 c, bus.cpt_activate, (c >= 2 && c <= 6));
      end else n_pass++;
      n_total++;
      if (bus.done !== ((c == 8) ? 4'b0001 : 4'b0000)) begin
        $display("FAIL single_done: cycle %0d got %b expected %b",
                 c, bus.done, (c == 8) ? 4'b0001 : 4'b0000);
      end else n_pass++;
      if (c == 8) begin
        e = exp_q.pop_front();
        n_total++;
        if (bus.done !== e.who || bus.cpt !== e.cnt) begin
          $display("FAIL single_score: got done=%b cpt=%0d expected done=%b cpt=%0d",
                   bus.done, bus.cpt, e.who, e.cnt);
        end else n_pass++;
        bus.req = '0;
      end
    end
    n_total++;
    if (bus.cpt !== 8'd5 || bus.busy !== 1'b0) begin
      $display("FAIL single_hold: got cpt=%0d busy=%b expected cpt=5 busy=0", bus.cpt, bus.busy);
    end else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]  g, d;
    logic [WIDTH-1:0] c;
    bit               to, sd;
    exp_t             e;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_len(i, 8'd2);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back('{who: 4'b0001 << (k % NREQ), cnt: 8'd2});
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(10, g, sd);
      e = exp_q.pop_front();
      n_total++;
      if (g !== e.who) begin
        $display("FAIL rr_grant: step %0d got %b expected %b", k, g, e.who);
      end else n_pass++;
      wait_done(20, d, c, to);
      if (k == 4) bus.req = '0;
      n_total++;
      if (to || d !== e.who || c !== e.cnt) begin
        $display("FAIL rr_done: step %0d got done=%b cpt=%0d timeout=%0d expected done=%b cpt=%0d",
                 k, d, c, to, e.who, e.cnt);
      end else n_pass++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_len();
    exp_t e;
    bit   act_seen = 1'b0;
    set_len(2, 8'd0);
    bus.req = 4'b0100;
    exp_q.push_back('{who: 4'b0100, cnt: 8'd0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (bus.cpt_activate !== 1'b0) act_seen = 1'b1;
      if (c == 1) begin
        n_total++;
        if (bus.grant !== 4'b0100) begin
          $display("FAIL zero_grant: got %b expected 0100", bus.grant);
        end else n_pass++;
      end
      if (c == 3) begin
        e = exp_q.pop_front();
        n_total++;
        if (bus.done !== e.who || bus.cpt !== e.cnt) begin
          $display("FAIL zero_done: got done=%b cpt=%0d expected done=%b cpt=%0d",
                   bus.done, bus.cpt, e.who, e.cnt);
        end else n_pass++;
        bus.req = '0;
      end
    end
    n_total++;
    if (act_seen || bus.busy !== 1'b0) begin
      $display("FAIL zero_activate: got act_seen=%b busy=%b expected 0 0", act_seen, bus.busy);
    end else n_pass++;
  endtask

  task automatic test_abort();
    logic [NREQ-1:0]  g, d;
    logic [WIDTH-1:0] c;
    bit               to, sd;
    bit               hit = 1'b0;
    exp_t             e;
    set_len(0, 8'd10);
    set_len(1, 8'd3);
    bus.req = 4'b0011;
    wait_grant(10, g, sd);
    n_total++;
    if (g !== 4'b0001) begin
      $display("FAIL abort_first_grant: got %b expected 0001", g);
    end else n_pass++;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.cpt === 8'd4) begin
        hit = 1'b1;
        break;
      end
    end
    bus.req = 4'b0010;
    exp_q.push_back('{who: 4'b0010, cnt: 8'd3});
    @(negedge clk);
    n_total++;
    if (!hit || bus.grant !== '0 || bus.done !== '0 || bus.cpt_activate !== 1'b0) begin
      $display("FAIL abort_drop: got reached=%b grant=%b done=%b act=%b expected 1 0000 0000 0",
               hit, bus.grant, bus.done, bus.cpt_activate);
    end else n_pass++;
    wait_grant(10, g, sd);
    e = exp_q.pop_front();
    n_total++;
    if (g !== e.who || sd) begin
      $display("FAIL abort_next_grant: got grant=%b done_seen=%b expected grant=%b done_seen=0",
               g, sd, e.who);
    end else n_pass++;
    wait_done(20, d, c, to);
    bus.req = '0;
    n_total++;
    if (to || d !== e.who || c !== e.cnt) begin
      $display("FAIL abort_second_done: got done=%b cpt=%0d timeout=%0d expected done=%b cpt=%0d",
               d, c, to, e.who, e.cnt);
    end else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_len();
    logic [NREQ-1:0]  d;
    logic [WIDTH-1:0] c;
    bit               to;
    exp_t             e;
    set_len(3, 8'd255);
    bus.req = 4'b1000;
    exp_q.push_back('{who: 4'b1000, cnt: 8'd255});
    wait_done(300, d, c, to);
    bus.req = '0;
    e = exp_q.pop_front();
    n_total++;
    if (to || d !== e.who || c !== e.cnt) begin
      $display("FAIL full_done: got done=%b cpt=%0d timeout=%0d expected done=%b cpt=%0d",
               d, c, to, e.who, e.cnt);
    end else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.cpt !== 8'd255) begin
      $display("FAIL full_no_wrap: got cpt=%0d expected 255", bus.cpt);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_count();
    bit hit    = 1'b0;
    bit d_seen = 1'b0;
    set_len(0, 8'd50);
    bus.req = 4'b0001;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.cpt === 8'd10) begin
        hit = 1'b1;
        break;
      end
    end
    n_total++;
    if (!hit || bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
      $display("FAIL midreset_running: got reached=%b grant=%b busy=%b expected 1 0001 1",
               hit, bus.grant, bus.busy);
    end else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (bus.grant !== '0 || bus.cpt_activate !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL midreset_async: got grant=%b act=%b busy=%b expected 0000 0 0",
               bus.grant, bus.cpt_activate, bus.busy);
    end else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done !== '0) d_seen = 1'b1;
    end
    bus.req = '0;
    reset   = 1'b1;
    @(negedge clk);
    if (bus.done !== '0) d_seen = 1'b1;
    n_total++;
    if (d_seen || bus.busy !== 1'b0) begin
      $display("FAIL midreset_no_done: got done_seen=%b busy=%b expected 0 0", d_seen, bus.busy);
    end else n_pass++;
  endtask

  initial begin
    bus.req = '0;
    bus.len = '0;
    test_reset();
    test_single_run();
    test_round_robin();
    test_zero_len();
    test_abort();
    test_full_len();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
